debug_uart_bridge: RTL and testbench
====================================

// Module: debug_uart_bridge
// PURPOSE
//  Bridges the MCU 32-bit debug port to the PMOD_E UART (8N1) on the Zybo board.
//  Downstream of mcu.DEBUG_O: each new value is sent as 8 uppercase hex chars plus CR LF.
//  Upstream of mcu.DEBUG_I: hex lines typed on the host are parsed into a 32-bit word.
//  Replaces the TXD/RXD loopback and bogus debug logic in the board top level.
// PARAMETERS
//  CLK_HZ        125000000  input clock frequency in Hz
//  BAUD          115200     line rate
//  CLKS_PER_BIT  CLK_HZ/BAUD (1085)  derived localparam, integer-truncated; must be >= 4
// PORTS
//  CLK_125MHZ_I  in   1   clock
//  reset         in   1   synchronous, active-high reset
//  DBG_WORD_I    in   32  word to transmit (from mcu DEBUG_O)
//  DBG_WORD_O    out  32  last parsed host word (to mcu DEBUG_I)
//  DBG_VALID_O   out  1   one-cycle pulse when DBG_WORD_O updates
//  TXD_O         out  1   UART transmit line (PMOD_E pin 2), idle high
//  RXD_I         in   1   UART receive line (PMOD_E pin 3), asynchronous
//  TX_BUSY_O     out  1   high while a 10-char message is in flight
//  RX_ERR_O      out  1   one-cycle pulse on framing error or illegal char
// BEHAVIOUR
//  Reset values: TXD_O=1, DBG_WORD_O=0, DBG_VALID_O=0, TX_BUSY_O=0, RX_ERR_O=0.
//  Reset mid-frame aborts TX immediately; TXD_O is high on the cycle after reset.
//  TX FSM: IDLE -> LOAD -> SEND_CHAR (start,8 data LSB-first,stop; CLKS_PER_BIT each) -> NEXT.
//   - IDLE starts when DBG_WORD_I != sent_q, or when first_q is set (first_q set by reset,
//     so one message always goes out after reset).
//   - LOAD latches DBG_WORD_I into sent_q and sets TX_BUSY_O. TXD_O goes low on the
//     second clock edge after IDLE sees the change.
//   - Char order: nibble[31:28] first .. nibble[3:0], then 0x0D, 0x0A. 0-9 -> 0x30-0x39,
//     A-F -> 0x41-0x46.
//   - No gap between chars. TX_BUSY_O drops in the cycle the last stop bit ends.
//   - DBG_WORD_I changes during a message are not queued. Only the value present on
//     return to IDLE is compared, so intermediate values are dropped.
//  RX engine: RXD_I passes through a 2-FF synchroniser (reset to 1).
//   - Falling edge -> wait CLKS_PER_BIT/2 and recheck. If high, it was a glitch: back to IDLE.
//   - Otherwise sample 8 data bits at mid-bit, then the stop bit.
//   - Stop=1: byte strobe. Stop=0: RX_ERR_O pulse and byte discarded.
//   - After a stop sample, wait for the line to be high before re-arming.
//  Hex parser (acts on byte strobe; acc[31:0], cnt[3:0]):
//   - '0'-'9','A'-'F','a'-'f': acc <= {acc[27:0],nib}; cnt saturates at 8, so only the
//     last 8 digits are kept.
//   - 0x0D or 0x0A with cnt>0: DBG_WORD_O <= acc (fewer digits are zero-extended).
//     DBG_VALID_O pulses on the next cycle. acc and cnt are cleared.
//   - 0x0D or 0x0A with cnt==0: ignored, so CRLF commits only once.
//   - Any other byte: RX_ERR_O pulse; acc and cnt are cleared.
//  TX and RX are fully independent; simultaneous activity has no interaction.
// STRUCTURE
//  Package ion_uart_pkg holds ASCII_CR/ASCII_LF constants, the nibble->ASCII and
//  ASCII->nibble/valid functions, and the CLKS_PER_BIT calculation.
//  One sub-module, uart_phy: shared baud counters, TX shifter (tx_start/tx_byte/tx_done)
//  and RX sampler (rx_strobe/rx_byte/rx_frame_err).
//  The top holds the message-sequencing FSM and the hex parser.
// TESTING (sim with CLK_HZ=1000, BAUD=100 -> 10 clks/bit)
//  1. Release reset with DBG_WORD_I=0 -> bytes "00000000\r\n" on TXD_O, 1000 clks total,
//     then TX_BUSY_O=0.
//  2. DBG_WORD_I=32'hDEADBEEF, then changed to 32'h1 and 32'h2 mid-message ->
//     "DEADBEEF\r\n" then exactly one "00000002\r\n".
//  3. Drive RXD_I "12ab34CD\r\n" -> DBG_WORD_O=32'h12AB34CD, exactly one DBG_VALID_O pulse.
//  4. RXD "123456789\n" -> 32'h23456789. Then "7\r" -> 32'h00000007.
//     Then "xZ\n" -> RX_ERR_O pulse, no VALID.
//  5. Byte with stop bit=0 -> RX_ERR_O pulse, parser unchanged.
//     A 3-clk low glitch -> no strobe, no error.
//  6. Assert reset at bit 4 of char 3 -> TXD_O=1 next cycle, outputs at reset values.
//     After release, a full message restarts.

Source files
------------

// File: rtl/ion_uart_pkg.sv
// Shared UART constants, ASCII/hex conversion helpers and FSM state types
// for the MCU debug-port UART bridge.
package ion_uart_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam int         MSG_CHARS = 10;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_digit_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SEND_CHAR,
    TX_NEXT
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
  endfunction

  // Letters share the low-nibble pattern 1..6 in both cases, so +9 gives A..F.
  function automatic hex_digit_t ascii_to_nib(input logic [7:0] c);
    hex_digit_t d;
    d = '{valid: 1'b0, nib: 4'h0};
    if (c >= 8'h30 && c <= 8'h39)
      d = '{valid: 1'b1, nib: c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      d = '{valid: 1'b1, nib: c[3:0] + 4'd9};
    return d;
  endfunction

  // Character idx of a message: 8 hex digits MSB nibble first, then CR, LF.
  function automatic logic [7:0] msg_char(input logic [31:0] word, input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd8:    c = ASCII_CR;
      4'd9:    c = ASCII_LF;
      default: c = nib_to_ascii(word[{3'd7 - idx[2:0], 2'b00} +: 4]);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/debug_uart_bridge_if.sv
// Byte-level link between the message/parser logic (master) and the UART
// line engine (slave).
interface debug_uart_bridge_if;

  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_done;
  logic       rx_strobe;
  logic [7:0] rx_byte;
  logic       rx_frame_err;

  modport master (
    output tx_start, tx_byte,
    input  tx_done, rx_strobe, rx_byte, rx_frame_err
  );

  modport slave (
    input  tx_start, tx_byte,
    output tx_done, rx_strobe, rx_byte, rx_frame_err
  );

endinterface

// File: rtl/debug_uart_bridge_uart_phy.sv
// 8N1 UART line engine: TX shifter that accepts back-to-back bytes without
// a gap, and an RX sampler with synchroniser, glitch rejection and framing check.
module uart_phy
  import ion_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic                CLK_125MHZ_I,
  input  logic                reset,
  input  logic                rxd_i,
  output logic                txd_o,
  debug_uart_bridge_if.slave  link
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          tx_active_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [8:0]    tx_frame_q;
  logic          txd_q;

  logic          rx_meta_q, rx_sync_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_strobe_q, rx_strobe_d;
  logic          rx_err_q, rx_err_d;

  // tx_done is asserted during the final stop-bit clock so the next start bit
  // can be loaded on the very next edge.
  assign link.tx_done = tx_active_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);
  assign txd_o        = txd_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK_125MHZ_I) begin
    if (reset) begin
      tx_active_q <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_frame_q  <= '1;
      txd_q       <= 1'b1;
    end else if (link.tx_start) begin
      tx_active_q <= 1'b1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_frame_q  <= {1'b1, link.tx_byte};
      txd_q       <= 1'b0;
    end else if (tx_active_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_active_q <= 1'b0;
          txd_q       <= 1'b1;
        end else begin
          tx_bit_q   <= tx_bit_q + 4'd1;
          txd_q      <= tx_frame_q[0];
          tx_frame_q <= {1'b1, tx_frame_q[8:1]};
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first; a missed branch then
  // holds the default instead of inferring a latch.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_strobe_d = 1'b0;
    rx_err_d    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_strobe_d = rx_sync_q;
        rx_err_d    = !rx_sync_q;
        rx_state_d  = RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_125MHZ_I) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_strobe_q <= 1'b0;
      rx_err_q    <= 1'b0;
    end else begin
      rx_meta_q   <= rxd_i;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_strobe_q <= rx_strobe_d;
      rx_err_q    <= rx_err_d;
    end
  end

  assign link.rx_strobe    = rx_strobe_q;
  assign link.rx_byte      = rx_shift_q;
  assign link.rx_frame_err = rx_err_q;

endmodule

// File: rtl/debug_uart_bridge.sv
// MCU debug port <-> UART bridge: sends each new DBG_WORD_I as "XXXXXXXX\r\n"
// and parses host hex lines into DBG_WORD_O.
module debug_uart_bridge
  import ion_uart_pkg::*;
#(
  parameter int CLK_HZ = 125000000,
  parameter int BAUD   = 115200
) (
  input  logic        CLK_125MHZ_I,
  input  logic        reset,
  input  logic [31:0] DBG_WORD_I,
  output logic [31:0] DBG_WORD_O,
  output logic        DBG_VALID_O,
  output logic        TXD_O,
  input  logic        RXD_I,
  output logic        TX_BUSY_O,
  output logic        RX_ERR_O
);

  localparam int         CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
  localparam logic [3:0] LAST_CHAR    = 4'(MSG_CHARS - 1);

  debug_uart_bridge_if link ();

  uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .CLK_125MHZ_I (CLK_125MHZ_I),
    .reset        (reset),
    .rxd_i        (RXD_I),
    .txd_o        (TXD_O),
    .link         (link)
  );

  tx_state_t   tx_state_q, tx_state_d;
  logic [31:0] sent_q, sent_d;
  logic        first_q, first_d;
  logic        busy_q, busy_d;
  logic [3:0]  char_idx_q, char_idx_d;

  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  hex_digit_t  rx_digit;

  // Characters chain back-to-back: the next start is issued in the same cycle
  // the phy reports the current stop bit ending.
  always_comb begin
    tx_state_d    = tx_state_q;
    sent_d        = sent_q;
    first_d       = first_q;
    busy_d        = busy_q;
    char_idx_d    = char_idx_q;
    link.tx_start = 1'b0;
    link.tx_byte  = msg_char(sent_q, char_idx_q);
    unique case (tx_state_q)
      TX_IDLE: if (first_q || (DBG_WORD_I != sent_q)) tx_state_d = TX_LOAD;
      TX_LOAD: begin
        sent_d        = DBG_WORD_I;
        first_d       = 1'b0;
        busy_d        = 1'b1;
        char_idx_d    = '0;
        link.tx_start = 1'b1;
        link.tx_byte  = msg_char(DBG_WORD_I, 4'd0);
        tx_state_d    = TX_SEND_CHAR;
      end
      TX_SEND_CHAR: if (link.tx_done) begin
        if (char_idx_q == LAST_CHAR) begin
          busy_d     = 1'b0;
          tx_state_d = TX_NEXT;
        end else begin
          char_idx_d    = char_idx_q + 4'd1;
          link.tx_start = 1'b1;
          link.tx_byte  = msg_char(sent_q, char_idx_q + 4'd1);
        end
      end
      TX_NEXT: tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign rx_digit = ascii_to_nib(link.rx_byte);

  // A terminator with no pending digits is ignored so CRLF commits only once.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    err_d   = link.rx_frame_err;
    if (link.rx_strobe) begin
      if (rx_digit.valid) begin
        acc_d = {acc_q[27:0], rx_digit.nib};
        if (cnt_q != 4'd8) cnt_d = cnt_q + 4'd1;
      end else if ((link.rx_byte == ASCII_CR) || (link.rx_byte == ASCII_LF)) begin
        if (cnt_q != 4'd0) begin
          word_d  = acc_q;
          valid_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end else begin
        err_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge CLK_125MHZ_I) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      sent_q     <= '0;
      first_q    <= 1'b1;
      busy_q     <= 1'b0;
      char_idx_q <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      sent_q     <= sent_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      char_idx_q <= char_idx_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign DBG_WORD_O  = word_q;
  assign DBG_VALID_O = valid_q;
  assign TX_BUSY_O   = busy_q;
  assign RX_ERR_O    = err_q;

endmodule

// File: tb/tb_debug_uart_bridge.sv
// Self-checking bench for debug_uart_bridge at 10 clocks per bit: a UART line
// monitor decodes TXD, and a line-level hex model predicts parsed words/errors.
module tb_debug_uart_bridge;

  localparam int CPB = 1000 / 100;

  logic        clk;
  logic        reset;
  logic [31:0] dbg_word_i;
  logic [31:0] dbg_word_o;
  logic        dbg_valid_o;
  logic        txd_o;
  logic        rxd_i;
  logic        tx_busy_o;
  logic        rx_err_o;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  debug_uart_bridge #(.CLK_HZ(1000), .BAUD(100)) dut (
    .CLK_125MHZ_I (clk),
    .reset        (reset),
    .DBG_WORD_I   (dbg_word_i),
    .DBG_WORD_O   (dbg_word_o),
    .DBG_VALID_O  (dbg_valid_o),
    .TXD_O        (txd_o),
    .RXD_I        (rxd_i),
    .TX_BUSY_O    (tx_busy_o),
    .RX_ERR_O     (rx_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  // Line monitor: decodes 8N1 frames on TXD, sampling mid-bit on falling clock edges.
  logic [7:0] tx_q[$];
  logic       mon_busy = 1'b0;
  logic       mon_ok;
  int         mon_cnt;
  logic [7:0] mon_byte;

  always @(negedge clk) begin
    if (reset) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (txd_o === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        mon_ok   = 1'b1;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        if (mon_cnt < CPB) begin
          if (txd_o !== 1'b0) mon_ok = 1'b0;
        end else if (mon_cnt < 9 * CPB) begin
          mon_byte = {txd_o, mon_byte[7:1]};
        end else begin
          if (txd_o !== 1'b1) mon_ok = 1'b0;
          tx_q.push_back(mon_ok ? mon_byte : 8'h00);
          mon_busy = 1'b0;
        end
      end
    end
  end

  // Parser outputs as seen by the MCU.
  logic [31:0] got_words[$];
  int          got_err = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (dbg_valid_o === 1'b1) got_words.push_back(dbg_word_o);
      if (rx_err_o === 1'b1) got_err++;
    end
  end

  // Reference model of the host-line protocol.
  logic [31:0] exp_words[$];
  int          exp_err = 0;
  logic [7:0]  pending[$];

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic [31:0] hex_val(input logic [7:0] c);
    return (c <= 8'h39) ? 32'(c - 8'h30) : 32'((c | 8'h20) - 8'h57);
  endfunction

  task automatic model_byte(input logic [7:0] c, input bit stop_ok);
    logic [31:0] v;
    int          first;
    if (!stop_ok) begin
      exp_err++;
    end else if (is_hex(c)) begin
      pending.push_back(c);
    end else if (c == 8'h0D || c == 8'h0A) begin
      if (pending.size() > 0) begin
        first = (pending.size() > 8) ? pending.size() - 8 : 0;
        v = 32'h0;
        for (int i = first; i < pending.size(); i++) v = v * 16 + hex_val(pending[i]);
        exp_words.push_back(v);
        pending.delete();
      end
    end else begin
      exp_err++;
      pending.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rxd_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd_i = stop_ok;
    repeat (CPB) @(negedge clk);
    rxd_i = 1'b1;
    repeat (2) @(negedge clk);
    model_byte(b, stop_ok);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic send_random_line();
    int          len;
    int          r;
    logic [7:0]  c;
    len = $urandom_range(1, 11);
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 21);
      if (r < 10)      c = 8'(8'h30 + r);
      else if (r < 16) c = 8'(8'h41 + r - 10);
      else             c = 8'(8'h61 + r - 16);
      send_byte(c, 1'b1);
    end
    r = $urandom_range(0, 2);
    if (r != 1) send_byte(8'h0D, 1'b1);
    if (r != 0) send_byte(8'h0A, 1'b1);
  endtask

  task automatic check_rx(input string tag);
    repeat (30) @(negedge clk);
    check({tag, ".valid_count"}, got_words.size(), exp_words.size());
    check({tag, ".err_count"}, got_err, exp_err);
    while (got_words.size() > 0 && exp_words.size() > 0)
      check({tag, ".word"}, got_words.pop_front(), exp_words.pop_front());
    got_words.delete();
    exp_words.delete();
  endtask

  // Compares the next 10 decoded TX bytes against the message for w.
  task automatic check_tx(input string tag, input logic [31:0] w);
    string hex;
    string obs;
    string exp;
    hex = $sformatf("%08h", w);
    hex = hex.toupper();
    exp = "";
    for (int i = 0; i < 8; i++) exp = {exp, $sformatf("%02h", hex[i])};
    exp = {exp, "0d0a"};
    obs = "";
    for (int i = 0; i < 10; i++)
      obs = {obs, (tx_q.size() > 0) ? $sformatf("%02h", tx_q.pop_front()) : "--"};
    check_str(tag, obs, exp);
  endtask

  task automatic wait_busy(input string tag, input logic lvl, input int max);
    int n;
    n = 0;
    while (tx_busy_o !== lvl && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, tx_busy_o, lvl);
  endtask

  task automatic send_word(input string tag, input logic [31:0] w);
    @(negedge clk);
    dbg_word_i = w;
    wait_busy({tag, ".start"}, 1'b1, 10);
    wait_busy({tag, ".end"}, 1'b0, 1100);
    repeat (5) @(negedge clk);
    check_tx({tag, ".msg"}, w);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          n;
  logic [31:0] w;

  initial begin
    reset      = 1'b1;
    dbg_word_i = 32'h0;
    rxd_i      = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset.txd", txd_o, 1'b1);
    check("reset.word", dbg_word_o, 32'h0);
    check("reset.valid", dbg_valid_o, 1'b0);
    check("reset.busy", tx_busy_o, 1'b0);
    check("reset.err", rx_err_o, 1'b0);

    // 1: one message after reset, start bit on the second edge, 1000 busy clocks.
    reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (txd_o !== 1'b0 && n < 20);
    check("t1.start_latency", n, 2);
    check("t1.busy_rise", tx_busy_o, 1'b1);
    n = 1;
    while (tx_busy_o === 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      if (tx_busy_o === 1'b1) n++;
    end
    check("t1.busy_cycles", n, 1000);
    check("t1.txd_idle", txd_o, 1'b1);
    repeat (5) @(negedge clk);
    check_tx("t1.msg", 32'h0);

    // 2: mid-message changes collapse to the value present on return to idle.
    @(negedge clk);
    dbg_word_i = 32'hDEADBEEF;
    wait_busy("t2.start1", 1'b1, 10);
    repeat (150) @(negedge clk);
    dbg_word_i = 32'h1;
    repeat (200) @(negedge clk);
    dbg_word_i = 32'h2;
    wait_busy("t2.end1", 1'b0, 1000);
    wait_busy("t2.start2", 1'b1, 10);
    wait_busy("t2.end2", 1'b0, 1100);
    repeat (300) @(negedge clk);
    check("t2.quiet", tx_busy_o, 1'b0);
    check_tx("t2.msg1", 32'hDEADBEEF);
    check_tx("t2.msg2", 32'h2);
    check("t2.no_extra", tx_q.size(), 0);

    w = 32'h2;
    for (int k = 0; k < 3; k++) begin
      w = (w ^ $urandom()) | 32'h1;
      send_word($sformatf("tx_rand%0d", k), w);
    end

    // 3-5: directed host lines, framing error and glitch rejection.
    send_str("12ab34CD\r\n");
    check_rx("t3");
    send_str("123456789\n");
    check_rx("t4a");
    send_str("7\r");
    check_rx("t4b");
    send_str("xZ\n");
    check_rx("t4c");
    send_byte(8'h39, 1'b1);
    send_byte(8'h35, 1'b0);
    send_str("\r");
    check_rx("t5.frame");
    @(negedge clk);
    rxd_i = 1'b0;
    repeat (3) @(negedge clk);
    rxd_i = 1'b1;
    check_rx("t5.glitch");
    send_str("A\n");
    check_rx("t5.after_glitch");

    for (int k = 0; k < 4; k++) begin
      send_random_line();
      check_rx($sformatf("rx_rand%0d", k));
    end

    // TX and RX running at the same time.
    w = (w ^ $urandom()) | 32'h1;
    fork
      send_random_line();
      send_word("concurrent", w);
    join
    check_rx("concurrent");

    // 6: reset in bit 4 of the third character aborts, then a full message restarts.
    w = (w ^ $urandom()) | 32'h1;
    @(negedge clk);
    dbg_word_i = w;
    wait_busy("t6.start", 1'b1, 10);
    repeat (2 * 10 * CPB + 4 * CPB + 3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6.txd", txd_o, 1'b1);
    check("t6.busy", tx_busy_o, 1'b0);
    check("t6.word", dbg_word_o, 32'h0);
    check("t6.valid", dbg_valid_o, 1'b0);
    check("t6.err", rx_err_o, 1'b0);
    repeat (3) @(negedge clk);
    tx_q.delete();
    pending.delete();
    reset = 1'b0;
    wait_busy("t6.restart", 1'b1, 10);
    wait_busy("t6.restart_end", 1'b0, 1100);
    repeat (5) @(negedge clk);
    check_tx("t6.msg", w);
    check("t6.no_extra", tx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
